cpu_lsu: RTL and testbench

CPU-side load/store port that drives the CPU -> L1D$ request interface and consumes the L1D -> CPU response. It buffers core memory commands in a small FIFO and issues one request at a time to the L1D. It converts size/offset into byte enables and lane-aligned write data, then extracts and extends load data from the returned word. It sits between the core's execute stage and `l1d`, and is the requester end of the `l1d` CPU port.

---
 rtl/cpu_lsu.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_lsu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_lsu.sv
// CPU-side load/store unit: queues core memory commands and issues them one at a time
// to the L1D, handling byte-lane steering for stores and load data extraction.
module cpu_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_store,
    input  logic [1:0]            cmd_size,
    input  logic                  cmd_signed,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  cpu_l1_valid,
    output logic                  cpu_l1_store,
    output logic [ADDR_WIDTH-1:0] cpu_l1_addr,
    output logic [DATA_WIDTH-1:0] cpu_l1_wdata,
    output logic [3:0]            cpu_l1_be,
    input  logic                  l1_cpu_ready,
    input  logic                  l1_cpu_resp_valid,
    input  logic [DATA_WIDTH-1:0] l1_cpu_rdata,
    output logic                  done_valid,
    output logic                  done_store,
    output logic                  done_err,
    output logic [DATA_WIDTH-1:0] done_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

    typedef struct packed {
        logic                  store;
        logic [1:0]            size;
        logic                  sgn;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop, full, empty;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full || pop;
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_store, cmd_size, cmd_signed, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    cmd_t                  head;
    logic [1:0]            head_off;
    logic                  head_legal;
    logic [3:0]            head_be;
    logic [DATA_WIDTH-1:0] head_wdata;

    assign head       = fifo_mem[rd_ptr];
    assign head_off   = head.addr[1:0];
    assign head_wdata = head.wdata << {head_off, 3'b000};

    always_comb begin
        head_legal = 1'b0;
        head_be    = 4'b0000;
        case (head.size)
            2'd0: begin head_legal = 1'b1;               head_be = 4'b0001 << head_off; end
            2'd1: begin head_legal = !head_off[0];       head_be = 4'b0011 << head_off; end
            2'd2: begin head_legal = (head_off == 2'd0); head_be = 4'b1111;             end
            default: ;
        endcase
    end

    state_t                state, state_n;
    logic [1:0]            req_size, req_size_n;
    logic                  req_sgn, req_sgn_n;
    logic [1:0]            req_off, req_off_n;
    logic                  l1_valid_n, l1_store_n;
    logic [ADDR_WIDTH-1:0] l1_addr_n;
    logic [DATA_WIDTH-1:0] l1_wdata_n;
    logic [3:0]            l1_be_n;
    logic                  done_valid_n, done_store_n, done_err_n;
    logic [DATA_WIDTH-1:0] done_data_n;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_data;

    always_comb begin
        case (req_off)
            2'd0:    ld_byte = l1_cpu_rdata[7:0];
            2'd1:    ld_byte = l1_cpu_rdata[15:8];
            2'd2:    ld_byte = l1_cpu_rdata[23:16];
            default: ld_byte = l1_cpu_rdata[31:24];
        endcase
        ld_half = req_off[1] ? l1_cpu_rdata[31:16] : l1_cpu_rdata[15:0];
        case (req_size)
            2'd0:    load_data = {{(DATA_WIDTH - 8){req_sgn & ld_byte[7]}}, ld_byte};
            2'd1:    load_data = {{(DATA_WIDTH - 16){req_sgn & ld_half[15]}}, ld_half};
            default: load_data = l1_cpu_rdata;
        endcase
    end

    always_comb begin
        state_n      = state;
        pop          = 1'b0;
        req_size_n   = req_size;
        req_sgn_n    = req_sgn;
        req_off_n    = req_off;
        l1_valid_n   = cpu_l1_valid;
        l1_store_n   = cpu_l1_store;
        l1_addr_n    = cpu_l1_addr;
        l1_wdata_n   = cpu_l1_wdata;
        l1_be_n      = cpu_l1_be;
        done_valid_n = 1'b0;
        done_store_n = 1'b0;
        done_err_n   = 1'b0;
        done_data_n  = '0;

        case (state)
            IDLE, ERR: begin
                state_n = IDLE;
                if (!empty) pop = 1'b1;
            end
            REQ: begin
                if (l1_cpu_ready) begin
                    state_n    = WAIT;
                    l1_valid_n = 1'b0;
                end
            end
            WAIT: begin
                if (l1_cpu_resp_valid) begin
                    state_n      = IDLE;
                    done_valid_n = 1'b1;
                    done_store_n = cpu_l1_store;
                    done_data_n  = cpu_l1_store ? '0 : load_data;
                    // An illegal head waits one cycle so its error pulse cannot collide with this completion.
                    if (!empty && head_legal) pop = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (pop) begin
            if (head_legal) begin
                state_n    = REQ;
                l1_valid_n = 1'b1;
                l1_store_n = head.store;
                l1_addr_n  = {head.addr[ADDR_WIDTH-1:2], 2'b00};
                l1_wdata_n = head_wdata;
                l1_be_n    = head_be;
                req_size_n = head.size;
                req_sgn_n  = head.sgn;
                req_off_n  = head_off;
            end else begin
                state_n      = ERR;
                done_valid_n = 1'b1;
                done_err_n   = 1'b1;
                done_store_n = head.store;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_size     <= '0;
            req_sgn      <= 1'b0;
            req_off      <= '0;
            cpu_l1_valid <= 1'b0;
            cpu_l1_store <= 1'b0;
            cpu_l1_addr  <= '0;
            cpu_l1_wdata <= '0;
            cpu_l1_be    <= '0;
            done_valid   <= 1'b0;
            done_store   <= 1'b0;
            done_err     <= 1'b0;
            done_data    <= '0;
        end else begin
            state        <= state_n;
            req_size     <= req_size_n;
            req_sgn      <= req_sgn_n;
            req_off      <= req_off_n;
            cpu_l1_valid <= l1_valid_n;
            cpu_l1_store <= l1_store_n;
            cpu_l1_addr  <= l1_addr_n;
            cpu_l1_wdata <= l1_wdata_n;
            cpu_l1_be    <= l1_be_n;
            done_valid   <= done_valid_n;
            done_store   <= done_store_n;
            done_err     <= done_err_n;
            done_data    <= done_data_n;
        end
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed scoreboard bench for cpu_lsu: commands push expected completions,
// a negedge monitor pops and compares them as done pulses appear.
module tb_cpu_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_store = 1'b0, cmd_signed = 1'b0;
    logic [1:0]  cmd_size = 2'd0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cpu_l1_valid, cpu_l1_store;
    logic [31:0] cpu_l1_addr, cpu_l1_wdata;
    logic [3:0]  cpu_l1_be;
    logic        l1_cpu_ready = 1'b0, l1_cpu_resp_valid = 1'b0;
    logic [31:0] l1_cpu_rdata = '0;
    logic        done_valid, done_store, done_err;
    logic [31:0] done_data;

    always #5 clk = ~clk;

    cpu_lsu dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_size(cmd_size), .cmd_signed(cmd_signed), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cpu_l1_valid(cpu_l1_valid), .cpu_l1_store(cpu_l1_store), .cpu_l1_addr(cpu_l1_addr),
        .cpu_l1_wdata(cpu_l1_wdata), .cpu_l1_be(cpu_l1_be),
        .l1_cpu_ready(l1_cpu_ready), .l1_cpu_resp_valid(l1_cpu_resp_valid), .l1_cpu_rdata(l1_cpu_rdata),
        .done_valid(done_valid), .done_store(done_store), .done_err(done_err), .done_data(done_data)
    );

    typedef struct {
        logic        store;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model_done(input logic store, input logic [1:0] size, input logic sgn,
                                        input logic [31:0] addr, input logic [31:0] rdata);
        exp_t        r;
        logic [1:0]  off;
        logic        ok;
        logic [7:0]  b;
        logic [15:0] h;
        off = addr[1:0];
        ok  = (size == 2'd0) || (size == 2'd1 && off[0] == 1'b0) || (size == 2'd2 && off == 2'd0);
        b   = 8'(rdata >> (8 * off));
        h   = 16'(rdata >> (8 * off));
        r.store = store;
        r.err   = !ok;
        r.data  = '0;
        if (ok && !store) begin
            case (size)
                2'd0:    r.data = sgn ? {{24{b[7]}}, b} : {24'h0, b};
                2'd1:    r.data = sgn ? {{16{h[15]}}, h} : {16'h0, h};
                default: r.data = rdata;
            endcase
        end
        return r;
    endfunction

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done_valid) begin
            if (exp_q.size() == 0) begin
                check_output("done_unexpected", done_valid, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("done_store", done_store, e.store);
                check_output("done_err", done_err, e.err);
                check_output("done_data", done_data, e.data);
            end
        end
    end

    task automatic apply_stimulus(input logic store, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        int waited = 0;
        cmd_valid  = 1'b1;
        cmd_store  = store;
        cmd_size   = size;
        cmd_signed = sgn;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        @(negedge clk);
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output("cmd_accept", cmd_ready, 32'd1);
        @(posedge clk);
        exp_q.push_back(model_done(store, size, sgn, addr, rdata));
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_l1_valid();
        int n = 0;
        while (!cpu_l1_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("l1_valid_seen", cpu_l1_valid, 32'd1);
    endtask

    task automatic l1_serve(input int stall, input int resp_delay, input logic [31:0] rdata,
                            input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wdata, input logic e_store);
        wait_l1_valid();
        check_output("l1_addr", cpu_l1_addr, e_addr);
        check_output("l1_be", cpu_l1_be, e_be);
        check_output("l1_wdata", cpu_l1_wdata, e_wdata);
        check_output("l1_store", cpu_l1_store, e_store);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_output("hold_valid", cpu_l1_valid, 32'd1);
            check_output("hold_addr", cpu_l1_addr, e_addr);
            check_output("hold_be", cpu_l1_be, e_be);
            check_output("hold_wdata", cpu_l1_wdata, e_wdata);
        end
        @(posedge clk);
        #1 l1_cpu_ready = 1'b1;
        @(posedge clk);
        #1 l1_cpu_ready = 1'b0;
        @(negedge clk);
        check_output("valid_drop", cpu_l1_valid, 32'd0);
        repeat (resp_delay) @(posedge clk);
        #1;
        l1_cpu_resp_valid = 1'b1;
        l1_cpu_rdata      = rdata;
        @(posedge clk);
        #1;
        l1_cpu_resp_valid = 1'b0;
        l1_cpu_rdata      = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_valid"}, cpu_l1_valid, 32'd0);
        check_output({tag, "_store"}, cpu_l1_store, 32'd0);
        check_output({tag, "_addr"}, cpu_l1_addr, 32'd0);
        check_output({tag, "_wdata"}, cpu_l1_wdata, 32'd0);
        check_output({tag, "_be"}, cpu_l1_be, 32'd0);
        check_output({tag, "_done_valid"}, done_valid, 32'd0);
        check_output({tag, "_done_store"}, done_store, 32'd0);
        check_output({tag, "_done_err"}, done_err, 32'd0);
        check_output({tag, "_done_data"}, done_data, 32'd0);
        check_output({tag, "_cmd_ready"}, cmd_ready, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Word load with issue-latency check
        @(posedge clk); #1;
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        check_output("issue_not_yet", cpu_l1_valid, 32'd0);
        @(negedge clk);
        check_output("issue_latency", cpu_l1_valid, 32'd1);
        l1_serve(0, 3, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 1'b0);

        // Signed and unsigned byte loads at offset 3
        apply_stimulus(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF0000);
        l1_serve(0, 1, 32'h80FF0000, 32'h100, 4'b1000, 32'h0, 1'b0);
        apply_stimulus(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF0000);
        l1_serve(0, 2, 32'h80FF0000, 32'h100, 4'b1000, 32'h0, 1'b0);

        // Signed half load at offset 2
        apply_stimulus(1'b0, 2'd1, 1'b1, 32'h402, 32'h0, 32'h80011234);
        l1_serve(0, 1, 32'h80011234, 32'h400, 4'b1100, 32'h0, 1'b0);

        // Half store with L1 stalled
        apply_stimulus(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h0);
        l1_serve(4, 2, 32'h0, 32'h200, 4'b1100, 32'hABCD0000, 1'b1);

        // Byte store at offset 1
        apply_stimulus(1'b1, 2'd0, 1'b0, 32'h501, 32'h0000005A, 32'h0);
        l1_serve(0, 1, 32'h0, 32'h500, 4'b0010, 32'h00005A00, 1'b1);

        // Five back-to-back commands with L1 stalled: one in REQ plus a full FIFO
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b0, 2'd2, 1'b0, 32'h10 + 32'(4 * i), 32'h0, 32'h11110000 + 32'(i));
        @(negedge clk);
        check_output("full_ready_low", cmd_ready, 32'd0);
        for (int i = 0; i < 5; i++)
            l1_serve(0, 1, 32'h11110000 + 32'(i), 32'h10 + 32'(4 * i), 4'b1111, 32'h0, 1'b0);

        // Misaligned word followed by a legal word
        repeat (2) @(posedge clk); #1;
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h12345678);
        @(negedge clk);
        check_output("err_no_issue", cpu_l1_valid, 32'd0);
        check_output("err_pulse", done_err, 32'd1);
        l1_serve(0, 2, 32'h12345678, 32'h104, 4'b1111, 32'h0, 1'b0);

        // Size 3 is always illegal
        apply_stimulus(1'b1, 2'd3, 1'b0, 32'h600, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check_output("size3_no_issue", cpu_l1_valid, 32'd0);

        // Reset while waiting with two ops queued, then a late response
        @(posedge clk); #1;
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'h0);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'h308, 32'h0, 32'h0);
        wait_l1_valid();
        @(posedge clk);
        #1 l1_cpu_ready = 1'b1;
        @(posedge clk);
        #1 l1_cpu_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst               = 1'b0;
        l1_cpu_resp_valid = 1'b1;
        l1_cpu_rdata      = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        l1_cpu_resp_valid = 1'b0;
        l1_cpu_rdata      = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_outputs("flush");
        end

        repeat (3) @(negedge clk);
        check_output("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
